// File: rtl/fir_mac_sequencer.sv
// Tap sequencer for the shared-MAC FIR: delay-line writes, tap addressing, accumulator strobes.
// Define FIR_FLUSH_EN to zero the delay line after every reset.
module fir_mac_sequencer #(
    parameter int DATA_WIDTH  = 24,
    parameter int FIR_DEPTH   = 32,
    parameter int MAC_LATENCY = 2,
    localparam int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_sample_valid,
    output logic                  o_sample_ready,
    output logic                  o_buf_we,
    output logic                  o_buf_zero,
    output logic [ADDR_WIDTH-1:0] o_buf_waddr,
    output logic [ADDR_WIDTH-1:0] o_buf_raddr,
    output logic [ADDR_WIDTH-1:0] o_coef_addr,
    output logic                  o_tap_valid,
    output logic                  o_acc_clr,
    output logic                  o_acc_en,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_busy
);

    localparam int LAT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FIR_DEPTH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAC_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(FIR_DEPTH);

    generate
        if (FIR_DEPTH < 2 || MAC_LATENCY < 1 || DATA_WIDTH < 1) begin : g_bad_cfg
            $error("fir_mac_sequencer: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
`ifdef FIR_FLUSH_EN
        S_OUT,
        S_FLUSH
`else
        S_OUT
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0]  r_wp;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH-1:0]  r_k;
    logic [LAT_W-1:0]       r_dcnt;
    logic [MAC_LATENCY-1:0] r_en_pipe;
    logic [MAC_LATENCY-1:0] r_clr_pipe;
    logic                   r_rv;

    logic                  w_ready;
    logic                  w_we;
    logic                  w_zero;
    logic                  w_tap;
    logic [ADDR_WIDTH-1:0] w_wp_inc;
    logic [ADDR_WIDTH:0]   w_diff;
    logic [ADDR_WIDTH:0]   w_diff_wrap;

    assign w_wp_inc = (r_wp == LAST) ? '0 : r_wp + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
`ifdef FIR_FLUSH_EN
            r_state <= S_FLUSH;
`else
            r_state <= S_IDLE;
`endif
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_zero  = 1'b0;
        w_tap   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_we    = i_sample_valid;
                if (i_sample_valid) w_next = S_MAC;
            end
            S_MAC: begin
                w_tap = 1'b1;
                if (r_k == LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_dcnt == LAT_LAST) w_next = S_OUT;
            end
            S_OUT: begin
                if (i_result_ready) w_next = S_IDLE;
            end
`ifdef FIR_FLUSH_EN
            S_FLUSH: begin
                w_we   = 1'b1;
                w_zero = 1'b1;
                if (r_wp == LAST) w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
        // Disable freezes the FSM in place and masks every strobe
        if (!i_en) begin
            w_next  = r_state;
            w_ready = 1'b0;
            w_we    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp       <= '0;
            r_base     <= '0;
            r_k        <= '0;
            r_dcnt     <= '0;
            r_en_pipe  <= '0;
            r_clr_pipe <= '0;
            r_rv       <= 1'b0;
        end else if (i_en) begin
            r_en_pipe[0]  <= w_tap;
            r_clr_pipe[0] <= w_tap && (r_k == '0);
            for (int i = 1; i < MAC_LATENCY; i++) begin
                r_en_pipe[i]  <= r_en_pipe[i-1];
                r_clr_pipe[i] <= r_clr_pipe[i-1];
            end
            r_rv <= (w_next == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (i_sample_valid) begin
                        r_base <= r_wp;
                        r_wp   <= w_wp_inc;
                        r_k    <= '0;
                    end
                end
                S_MAC: begin
                    r_dcnt <= '0;
                    if (r_k != LAST) r_k <= r_k + 1'b1;
                end
                S_DRAIN: r_dcnt <= r_dcnt + 1'b1;
`ifdef FIR_FLUSH_EN
                S_FLUSH: r_wp <= w_wp_inc;
`endif
                default: ;
            endcase
        end
    end

    // Newest sample sits at base, so tap k reads base-k modulo the depth
    assign w_diff      = {1'b0, r_base} - {1'b0, r_k};
    assign w_diff_wrap = w_diff + DEPTH_X;
    assign o_buf_raddr = (r_k > r_base) ? w_diff_wrap[ADDR_WIDTH-1:0]
                                        : w_diff[ADDR_WIDTH-1:0];

    assign o_coef_addr    = r_k;
    assign o_buf_waddr    = r_wp;
    assign o_sample_ready = w_ready;
    assign o_buf_we       = w_we;
    assign o_buf_zero     = w_zero;
    assign o_tap_valid    = w_tap & i_en;
    assign o_acc_en       = r_en_pipe[MAC_LATENCY-1] & i_en;
    assign o_acc_clr      = r_clr_pipe[MAC_LATENCY-1] & i_en;
    assign o_result_valid = r_rv;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer at default parameters (32 taps, latency 2).
module tb_fir_mac_sequencer;

    logic       i_clk;
    logic       i_rst;
    logic       i_en;
    logic       i_sample_valid;
    logic       o_sample_ready;
    logic       o_buf_we;
    logic       o_buf_zero;
    logic [4:0] o_buf_waddr;
    logic [4:0] o_buf_raddr;
    logic [4:0] o_coef_addr;
    logic       o_tap_valid;
    logic       o_acc_clr;
    logic       o_acc_en;
    logic       o_result_valid;
    logic       i_result_ready;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;

    fir_mac_sequencer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_en           (i_en),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_buf_we       (o_buf_we),
        .o_buf_zero     (o_buf_zero),
        .o_buf_waddr    (o_buf_waddr),
        .o_buf_raddr    (o_buf_raddr),
        .o_coef_addr    (o_coef_addr),
        .o_tap_valid    (o_tap_valid),
        .o_acc_clr      (o_acc_clr),
        .o_acc_en       (o_acc_en),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One accept plus its full tap sweep; hold = OUT cycles with ready low,
    // stall = disabled cycles starting at k=10.
    task automatic run_one(input int wa, input int hold, input int stall);
        int last;
        int e;
        int k;
        i_result_ready = (hold == 0);
        i_sample_valid = 1'b1;
        #1;
        chk("idle_rv", o_result_valid, 0);
        chk("idle_busy", o_busy, 0);
        chk("acc_ready", o_sample_ready, 1);
        chk("acc_we", o_buf_we, 1);
        chk("acc_waddr", o_buf_waddr, wa);
        tick();
        i_sample_valid = 1'b0;
        last = 35 + hold + stall;
        for (int t = 1; t <= last; t++) begin
            i_en = !(stall > 0 && t >= 11 && t < 11 + stall);
            e = (t < 11) ? t : (t < 11 + stall) ? 0 : t - stall;
            if (hold > 0) begin
                i_result_ready = (e >= 35 + hold);
                i_sample_valid = (e >= 35);
            end
            #1;
            if (e == 0) begin
                chk("stall_tap", o_tap_valid, 0);
                chk("stall_acc_en", o_acc_en, 0);
                chk("stall_acc_clr", o_acc_clr, 0);
                chk("stall_coef", o_coef_addr, 10);
                chk("stall_raddr", o_buf_raddr, (wa + 22) % 32);
                chk("stall_rv", o_result_valid, 0);
            end else begin
                k = e - 1;
                chk("tap", o_tap_valid, (e <= 32));
                if (e <= 32) begin
                    chk("coef", o_coef_addr, k);
                    chk("raddr", o_buf_raddr, (wa - k + 32) % 32);
                end
                chk("acc_clr", o_acc_clr, (e == 3));
                chk("acc_en", o_acc_en, (e >= 3 && e <= 34));
                chk("rv", o_result_valid, (e >= 35));
            end
            chk("busy", o_busy, 1);
            chk("sready", o_sample_ready, 0);
            chk("we_off", o_buf_we, 0);
            tick();
        end
        i_en           = 1'b1;
        i_sample_valid = 1'b0;
        i_result_ready = 1'b1;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_en           = 1'b1;
        i_sample_valid = 1'b0;
        i_result_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        chk("rst_ready", o_sample_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_we", o_buf_we, 0);
        chk("rst_zero", o_buf_zero, 0);
        chk("rst_waddr", o_buf_waddr, 0);
        chk("rst_raddr", o_buf_raddr, 0);
        chk("rst_coef", o_coef_addr, 0);
        chk("rst_tap", o_tap_valid, 0);
        chk("rst_clr", o_acc_clr, 0);
        chk("rst_acc_en", o_acc_en, 0);
        chk("rst_rv", o_result_valid, 0);
        tick();

        run_one(0, 0, 0);

        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) run_one(i, 0, 0);

        for (int i = 10; i < 32; i++) run_one(i, 0, 0);
        run_one(0, 0, 0);

        run_one(1, 20, 0);
        run_one(2, 0, 5);

        i_sample_valid = 1'b1;
        #1;
        chk("mid_waddr", o_buf_waddr, 3);
        tick();
        i_sample_valid = 1'b0;
        for (int t = 1; t < 16; t++) tick();
        #1;
        chk("mid_coef", o_coef_addr, 15);
        chk("mid_tap", o_tap_valid, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        #1;
        chk("mrst_tap", o_tap_valid, 0);
        chk("mrst_acc_en", o_acc_en, 0);
        chk("mrst_clr", o_acc_clr, 0);
        chk("mrst_rv", o_result_valid, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_ready", o_sample_ready, 1);
        chk("mrst_waddr", o_buf_waddr, 0);
        for (int t = 0; t < 40; t++) begin
            tick();
            chk("mrst_no_rv", o_result_valid, 0);
            chk("mrst_idle", o_busy, 0);
        end
        tick();
        run_one(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
